led_frame_scanner: RTL and testbench

LED_FRAME_SCANNER -- requirements
Module: led_frame_scanner

---
 rtl/led_frame_scanner.sv | 140 ++++++++++++++
 tb/tb_led_frame_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_scanner.sv
// rtl/led_frame_scanner.sv - reads one 24-bit GRB word per LED from RAM and serialises it
// onto a single-wire LED line with a low latch period after each frame.
module led_frame_scanner #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_LEDS   = 64,
  parameter int T0H        = 4,
  parameter int T1H        = 8,
  parameter int TBIT       = 15,
  parameter int TRST       = 600
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_continuous,
  output logic                  o_mem_en,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_led_dout,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int CMAX = (TBIT > TRST) ? TBIT : TRST;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]         BIT_LAST   = CW'(TBIT - 1);
  localparam logic [CW-1:0]         LATCH_LAST = CW'(TRST - 1);
  localparam logic [CW-1:0]         HIGH_ZERO  = CW'(T0H);
  localparam logic [CW-1:0]         HIGH_ONE   = CW'(T1H);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_LEDS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] SEND    = 3'd3;
  localparam logic [2:0] LATCH   = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [4:0]            bit_cnt;
  logic [CW-1:0]         cyc;
  logic [23:0]           shreg;
  logic [CW-1:0]         cyc_next;
  logic [CW-1:0]         high_len;
  logic                  unused_data;

  assign o_mem_wr_en = 1'b0;
  assign cyc_next    = cyc + 1'b1;
  assign high_len    = shreg[23] ? HIGH_ONE : HIGH_ZERO;
  // Only the low 24 bits of a RAM word carry colour.
  assign unused_data = ^i_mem_data;

  // Every output is loaded alongside the state it belongs to, so each is a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      bit_cnt      <= '0;
      cyc          <= '0;
      shreg        <= '0;
      o_mem_en     <= 1'b0;
      o_mem_addr   <= '0;
      o_led_dout   <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_mem_en     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= FETCH;
            idx        <= '0;
            o_mem_addr <= '0;
            o_mem_en   <= 1'b1;
            o_busy     <= 1'b1;
          end
        end
        FETCH: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          shreg      <= i_mem_data[23:0];
          bit_cnt    <= '0;
          cyc        <= '0;
          o_led_dout <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (cyc == BIT_LAST) begin
            cyc <= '0;
            if (bit_cnt == 5'd23) begin
              o_led_dout <= 1'b0;
              if (idx < LAST_IDX) begin
                idx        <= idx + 1'b1;
                o_mem_addr <= idx + 1'b1;
                o_mem_en   <= 1'b1;
                state      <= FETCH;
              end else begin
                state <= LATCH;
              end
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              shreg      <= {shreg[22:0], 1'b0};
              o_led_dout <= 1'b1;
            end
          end else begin
            cyc        <= cyc_next;
            o_led_dout <= (cyc_next < high_len);
          end
        end
        LATCH: begin
          if (cyc == LATCH_LAST) begin
            cyc          <= '0;
            o_frame_done <= 1'b1;
            if (i_continuous) begin
              state      <= FETCH;
              idx        <= '0;
              o_mem_addr <= '0;
              o_mem_en   <= 1'b1;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cyc <= cyc_next;
          end
        end
        default: begin
          state      <= IDLE;
          o_busy     <= 1'b0;
          o_led_dout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_scanner.sv
// tb/tb_led_frame_scanner.sv - scoreboard bench: expected fetches, LED words and frame-done
// timing are queued at issue time and consumed by a line-decoding monitor.
module tb_led_frame_scanner;

  localparam int DW = 32, AW = 6, NL = 2, T0H = 4, T1H = 8, TBIT = 15, TRST = 600;
  localparam int FRAME_DONE = NL * (2 + 24 * TBIT) + TRST + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          mem_en, mem_wr_en, dout, busy, frame_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  typedef struct {
    int cyc;
    bit cont;
  } done_t;

  int          exp_addr[$];
  logic [23:0] exp_word[$];
  done_t       exp_done[$];

  int checks = 0, passes = 0, done_count = 0, frame_cyc = 0;
  bit prev_dout = 0, have_prev = 0;
  int hi_run = 0, lo_run = 0, last_hi = 0, nbits = 0;
  logic [23:0] bits = '0;

  led_frame_scanner #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LEDS(NL),
    .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_continuous(cont),
    .o_mem_en(mem_en),
    .o_mem_wr_en(mem_wr_en),
    .o_mem_addr(mem_addr),
    .i_mem_data(mem_rdata),
    .o_led_dout(dout),
    .o_busy(busy),
    .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_frame(input bit c);
    done_t d;
    for (int i = 0; i < NL; i++) begin
      exp_addr.push_back(i);
      exp_word.push_back(mem[i][23:0]);
    end
    d.cyc  = FRAME_DONE;
    d.cont = c;
    exp_done.push_back(d);
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int s = done_count;
    int k = 0;
    while (done_count == s && k < 2 * FRAME_DONE) begin
      @(posedge clk);
      k++;
    end
    check(done_count > s, name, done_count - s, 1);
  endtask

  // Monitor: decodes the LED line into bits and words, and consumes the expectation queues.
  always @(negedge clk) begin : monitor
    int    a;
    done_t d;
    bit    b;
    logic [23:0] w;
    if (!rst_n) begin
      prev_dout = 0; hi_run = 0; lo_run = 0; nbits = 0; have_prev = 0; frame_cyc = 0;
    end else begin
      frame_cyc++;
      check(mem_wr_en == 1'b0, "wr_en_zero", mem_wr_en, 0);
      check(mem_addr < NL, "addr_range", mem_addr, NL - 1);
      if (mem_en) begin
        check(dout == 1'b0, "dout_low_in_fetch", dout, 0);
        if (exp_addr.size() == 0) check(0, "unexpected_fetch", mem_addr, 0);
        else begin
          a = exp_addr.pop_front();
          check(mem_addr == a, "fetch_addr", mem_addr, a);
        end
      end
      if (frame_done) begin
        done_count++;
        have_prev = 0;
        if (exp_done.size() == 0) check(0, "unexpected_frame_done", frame_cyc, 0);
        else begin
          d = exp_done.pop_front();
          check(frame_cyc == d.cyc, "frame_done_cycle", frame_cyc, d.cyc);
          check(busy == d.cont, "busy_at_done", busy, d.cont);
          check(mem_en == d.cont, "continuous_fetch", mem_en, d.cont);
        end
      end
      if (mem_en && mem_addr == 0) frame_cyc = 1;
      if (dout) begin
        if (!prev_dout) begin
          if (nbits > 0) check(lo_run == TBIT - last_hi, "bit_low_width", lo_run, TBIT - last_hi);
          else if (have_prev) check(lo_run == TBIT - last_hi + 2, "led_gap", lo_run, TBIT - last_hi + 2);
        end
        hi_run++;
        lo_run = 0;
      end else begin
        if (prev_dout) begin
          check(hi_run == T1H || hi_run == T0H, "high_width", hi_run, T0H);
          b = (hi_run == T1H);
          bits = {bits[22:0], b};
          nbits++;
          last_hi = hi_run;
          hi_run = 0;
          if (nbits == 24) begin
            nbits = 0;
            have_prev = 1;
            if (exp_word.size() == 0) check(0, "unexpected_word", bits, 0);
            else begin
              w = exp_word.pop_front();
              check(bits == w, "led_word", bits, w);
            end
          end
        end
        lo_run++;
      end
      prev_dout = dout;
    end
  end

  initial begin
    bit found;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check(busy == 0 && mem_en == 0 && dout == 0 && frame_done == 0 && mem_addr == 0,
          "reset_state", {busy, mem_en, dout, frame_done, 26'(mem_addr)}, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Reference frame: two LEDs, mixed bit pattern, upper byte ignored.
    mem[0] = 32'h00FF00AA;
    mem[1] = 32'h12800001;
    push_frame(0);
    pulse_start();
    wait_done("frame_reference");

    // All-zero colour from upper-byte-only word; start pulse mid-SEND must be ignored.
    mem[0] = 32'hFF000000;
    mem[1] = $urandom;
    push_frame(0);
    pulse_start();
    repeat (300) @(posedge clk);
    pulse_start();
    wait_done("frame_zero_bits");
    repeat (50) @(posedge clk);
    #1 check(busy == 1'b0, "no_second_frame", busy, 0);

    // Random frames with random idle gaps.
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NL; i++) mem[i] = $urandom;
      repeat ($urandom_range(1, 20)) @(posedge clk);
      push_frame(0);
      pulse_start();
      wait_done("frame_random");
    end

    // Continuous mode: second frame follows without i_start.
    for (int i = 0; i < NL; i++) mem[i] = $urandom;
    cont = 1'b1;
    push_frame(1);
    push_frame(0);
    pulse_start();
    wait_done("frame_cont_first");
    #2 cont = 1'b0;
    wait_done("frame_cont_second");

    // i_start held high: restart straight after frame_done.
    for (int i = 0; i < NL; i++) mem[i] = $urandom;
    push_frame(0);
    push_frame(0);
    @(posedge clk); #2 start = 1'b1;
    wait_done("frame_held_first");
    #2 start = 1'b0;
    wait_done("frame_held_second");
    repeat (50) @(posedge clk);
    #1 check(busy == 1'b0, "held_idle_after", busy, 0);

    // Asynchronous reset while the line is high mid-bit.
    push_frame(0);
    pulse_start();
    repeat (100) @(posedge clk);
    found = 0;
    for (int k = 0; k < 2 * TBIT && !found; k++) begin
      @(negedge clk);
      if (dout) found = 1;
    end
    check(found, "found_high_bit", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check(dout == 1'b0, "reset_async_dout", dout, 0);
    check(busy == 1'b0 && mem_en == 1'b0, "reset_async_ctrl", {busy, mem_en}, 0);
    exp_addr.delete();
    exp_word.delete();
    exp_done.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1 check(busy == 1'b0, "idle_after_reset", busy, 0);
    for (int i = 0; i < NL; i++) mem[i] = $urandom;
    push_frame(0);
    pulse_start();
    wait_done("frame_after_reset");

    repeat (20) @(posedge clk);
    check(exp_addr.size() == 0, "addr_queue_empty", exp_addr.size(), 0);
    check(exp_word.size() == 0, "word_queue_empty", exp_word.size(), 0);
    check(exp_done.size() == 0, "done_queue_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
